suprloco_sram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of one single-port synchronous SRAM instance (registered read data, one-cycle read latency, write wins over read). Shares the RAM between a CPU port (request/acknowledge, read or write) and a video fetch port (read-only strobes), with video priority and a bounded CPU wait. Sits between the CPU bus decode and the VRAM/work-RAM instance in the SuprLoco core.

---
 rtl/suprloco_sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_suprloco_sram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/suprloco_sram_arbiter.sv
// suprloco_sram_arbiter: shares one single-port synchronous SRAM between
// a CPU req/ack port and a read-only video strobe port.
//   Video has priority, and the CPU overrides video after MAXWAIT wait cycles.
//   Ports: i_MCLK/i_RST_n; CPU i_CPU_REQ/WR/ADDR/DIN -> o_CPU_DOUT/ACK;
//   video i_VID_REQ/ADDR -> o_VID_DOUT/VALID/OVF; SRAM o_RAM_* / i_RAM_DOUT.
module suprloco_sram_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 8,
    parameter int MAXWAIT = 3
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_CPU_REQ,
    input  logic          i_CPU_WR,
    input  logic [AW-1:0] i_CPU_ADDR,
    input  logic [DW-1:0] i_CPU_DIN,
    output logic [DW-1:0] o_CPU_DOUT,
    output logic          o_CPU_ACK,
    input  logic          i_VID_REQ,
    input  logic [AW-1:0] i_VID_ADDR,
    output logic [DW-1:0] o_VID_DOUT,
    output logic          o_VID_VALID,
    output logic          o_VID_OVF,
    output logic [AW-1:0] o_RAM_ADDR,
    output logic [DW-1:0] o_RAM_DIN,
    output logic          o_RAM_RD,
    output logic          o_RAM_WR,
    input  logic [DW-1:0] i_RAM_DOUT
);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CPUR,
        TAG_CPUW,
        TAG_VID
    } tag_t;

    localparam logic [3:0] LP_MAXW = 4'(MAXWAIT);

    tag_t          r_tag1;
    tag_t          r_tag2;
    logic          r_vid_pend;
    logic [AW-1:0] r_vid_addr;
    logic [3:0]    r_wait;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic          r_ram_rd;
    logic          r_ram_wr;
    logic [DW-1:0] r_cpu_dout;
    logic          r_cpu_ack;
    logic [DW-1:0] r_vid_dout;
    logic          r_vid_valid;
    logic          r_vid_ovf;

    logic          w_cpu_busy;
    logic          w_cpu_elig;
    logic          w_vid_cand;
    logic [AW-1:0] w_vid_addr;
    logic          w_cpu_ovr;
    logic          w_gnt_cpu;
    logic          w_gnt_vid;

    // CPU stays busy from issue until the end of its ACK cycle.
    assign w_cpu_busy = (r_tag1 == TAG_CPUR) || (r_tag1 == TAG_CPUW) ||
                        (r_tag2 == TAG_CPUR) || (r_tag2 == TAG_CPUW) ||
                        r_cpu_ack;
    assign w_cpu_elig = i_CPU_REQ && !w_cpu_busy;
    assign w_vid_cand = r_vid_pend || i_VID_REQ;
    assign w_vid_addr = r_vid_pend ? r_vid_addr : i_VID_ADDR;
    assign w_cpu_ovr  = w_cpu_elig && (r_wait == LP_MAXW);
    assign w_gnt_cpu  = w_cpu_ovr || (w_cpu_elig && !w_vid_cand);
    assign w_gnt_vid  = !w_cpu_ovr && w_vid_cand;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_tag1      <= TAG_NONE;
            r_tag2      <= TAG_NONE;
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= '0;
            r_wait      <= '0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_cpu_dout  <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_dout  <= '0;
            r_vid_valid <= 1'b0;
            r_vid_ovf   <= 1'b0;
        end else begin
            // RAM command for the next cycle
            r_ram_rd <= w_gnt_vid || (w_gnt_cpu && !i_CPU_WR);
            r_ram_wr <= w_gnt_cpu && i_CPU_WR;
            if (w_gnt_vid) begin
                r_ram_addr <= w_vid_addr;
            end else if (w_gnt_cpu) begin
                r_ram_addr <= i_CPU_ADDR;
                if (i_CPU_WR) begin
                    r_ram_din <= i_CPU_DIN;
                end
            end

            // Tag pipeline: issue -> RAM cycle -> data cycle
            if (w_gnt_vid) begin
                r_tag1 <= TAG_VID;
            end else if (w_gnt_cpu) begin
                r_tag1 <= i_CPU_WR ? TAG_CPUW : TAG_CPUR;
            end else begin
                r_tag1 <= TAG_NONE;
            end
            r_tag2 <= r_tag1;

            r_cpu_ack   <= (r_tag2 == TAG_CPUR) || (r_tag2 == TAG_CPUW);
            r_vid_valid <= (r_tag2 == TAG_VID);
            if (r_tag2 == TAG_CPUR) begin
                r_cpu_dout <= i_RAM_DOUT;
            end
            if (r_tag2 == TAG_VID) begin
                r_vid_dout <= i_RAM_DOUT;
            end

            // One-entry video deferral slot; a strobe that finds it full is lost.
            if (r_vid_pend) begin
                if (w_gnt_vid) begin
                    r_vid_pend <= 1'b0;
                end
                if (i_VID_REQ) begin
                    r_vid_ovf <= 1'b1;
                end
            end else if (i_VID_REQ && !w_gnt_vid) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= i_VID_ADDR;
            end

            // CPU wait counter
            if (w_gnt_cpu || !w_cpu_elig) begin
                r_wait <= '0;
            end else if (r_wait != LP_MAXW) begin
                r_wait <= r_wait + 4'd1;
            end
        end
    end

    assign o_RAM_ADDR  = r_ram_addr;
    assign o_RAM_DIN   = r_ram_din;
    assign o_RAM_RD    = r_ram_rd;
    assign o_RAM_WR    = r_ram_wr;
    assign o_CPU_DOUT  = r_cpu_dout;
    assign o_CPU_ACK   = r_cpu_ack;
    assign o_VID_DOUT  = r_vid_dout;
    assign o_VID_VALID = r_vid_valid;
    assign o_VID_OVF   = r_vid_ovf;

endmodule

// File: tb/tb_suprloco_sram_arbiter.sv
// tb_suprloco_sram_arbiter: scoreboard bench for suprloco_sram_arbiter
// with a behavioural single-port SRAM (registered read, write wins).
module tb_suprloco_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic [DW-1:0] o_CPU_DOUT;
    logic          o_CPU_ACK;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] o_VID_DOUT;
    logic          o_VID_VALID;
    logic          o_VID_OVF;
    logic [AW-1:0] o_RAM_ADDR;
    logic [DW-1:0] o_RAM_DIN;
    logic          o_RAM_RD;
    logic          o_RAM_WR;
    logic [DW-1:0] ram_q = '0;

    always #5 clk = ~clk;

    suprloco_sram_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(3)) dut (
        .i_MCLK      (clk),
        .i_RST_n     (rst_n),
        .i_CPU_REQ   (cpu_req),
        .i_CPU_WR    (cpu_wr),
        .i_CPU_ADDR  (cpu_addr),
        .i_CPU_DIN   (cpu_din),
        .o_CPU_DOUT  (o_CPU_DOUT),
        .o_CPU_ACK   (o_CPU_ACK),
        .i_VID_REQ   (vid_req),
        .i_VID_ADDR  (vid_addr),
        .o_VID_DOUT  (o_VID_DOUT),
        .o_VID_VALID (o_VID_VALID),
        .o_VID_OVF   (o_VID_OVF),
        .o_RAM_ADDR  (o_RAM_ADDR),
        .o_RAM_DIN   (o_RAM_DIN),
        .o_RAM_RD    (o_RAM_RD),
        .o_RAM_WR    (o_RAM_WR),
        .i_RAM_DOUT  (ram_q)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] d;
    } cexp_t;

    cexp_t         cq[$];
    logic [DW-1:0] vq[$];
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] exp_mem[1024];
    logic [DW-1:0] mem[1024];
    logic          load = 1'b1;
    bit            run = 1'b0;

    function automatic logic [DW-1:0] init_val(input int a);
        case (a)
            'h10:    return 8'h55;
            'h11:    return 8'h66;
            'h12:    return 8'h77;
            default: return 8'((a * 7 + 3) & 255);
        endcase
    endfunction

    // SRAM model
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (o_RAM_WR) begin
            mem[o_RAM_ADDR] <= o_RAM_DIN;
        end else if (o_RAM_RD) begin
            ram_q <= mem[o_RAM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string t);
        check({t, "_addr"}, 32'(o_RAM_ADDR), 0);
        check({t, "_din"}, 32'(o_RAM_DIN), 0);
        check({t, "_rd"}, 32'(o_RAM_RD), 0);
        check({t, "_wr"}, 32'(o_RAM_WR), 0);
        check({t, "_cdout"}, 32'(o_CPU_DOUT), 0);
        check({t, "_ack"}, 32'(o_CPU_ACK), 0);
        check({t, "_vdout"}, 32'(o_VID_DOUT), 0);
        check({t, "_valid"}, 32'(o_VID_VALID), 0);
        check({t, "_ovf"}, 32'(o_VID_OVF), 0);
    endtask

    task automatic cpu_op(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int n;
        cq.push_back({wr, wr ? 8'h00 : exp_mem[a]});
        if (wr) exp_mem[a] = d;
        cpu_req = 1'b1;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_din = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_CPU_ACK && n < 20);
        check("cpu_lat", 32'(n), 3);
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        tick();
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        cexp_t e;
        if (run) begin
            check("rdwr_excl", 32'(o_RAM_RD & o_RAM_WR), 0);
            if (o_VID_VALID) begin
                check("vid_sb", 32'(vq.size() > 0), 1);
                if (vq.size() > 0)
                    check("vid_dout", 32'(o_VID_DOUT), 32'(vq.pop_front()));
            end
            if (o_CPU_ACK) begin
                check("cpu_sb", 32'(cq.size() > 0), 1);
                if (cq.size() > 0) begin
                    e = cq.pop_front();
                    if (e.wr) begin
                        check("cpu_wr_hold", 32'(o_CPU_DOUT), 32'(last_rd));
                    end else begin
                        check("cpu_rdata", 32'(o_CPU_DOUT), 32'(e.d));
                        last_rd = e.d;
                    end
                end
            end
        end
    end

    initial begin
        bit got;
        logic [8:0] am;
        logic [8:0] rm;
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst_in");
        load = 1'b0;
        rst_n = 1'b1;
        run = 1'b1;
        tick();
        chk_idle("rst_out");

        // T1: write 0x3A5 <= 0xC7, then read back
        cq.push_back({1'b1, 8'h00});
        exp_mem[10'h3A5] = 8'hC7;
        cpu_req = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = 10'h3A5;
        cpu_din = 8'hC7;
        tick();
        check("t1_wr", 32'(o_RAM_WR), 1);
        check("t1_rd", 32'(o_RAM_RD), 0);
        check("t1_addr", 32'(o_RAM_ADDR), 32'h3A5);
        check("t1_din", 32'(o_RAM_DIN), 32'hC7);
        tick();
        check("t1_wr_1cyc", 32'(o_RAM_WR), 0);
        tick();
        check("t1_ack", 32'(o_CPU_ACK), 1);
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        tick();
        cpu_op(1'b0, 10'h3A5, 8'h00);

        // T2: three back-to-back video strobes
        for (int i = 0; i < 3; i++) begin
            vid_req = 1'b1;
            vid_addr = 10'(16 + i);
            vq.push_back(init_val(16 + i));
            tick();
        end
        vid_req = 1'b0;
        check("t2_v0", 32'(o_VID_VALID), 1);
        tick();
        check("t2_v1", 32'(o_VID_VALID), 1);
        tick();
        check("t2_v2", 32'(o_VID_VALID), 1);
        tick();
        check("t2_v3", 32'(o_VID_VALID), 0);
        check("t2_ovf", 32'(o_VID_OVF), 0);
        tick();

        // T3: video stream vs CPU read, override on 4th edge
        got = 1'b0;
        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 10'h3A5;
        cq.push_back({1'b0, exp_mem[10'h3A5]});
        for (int c = 0; c < 9; c++) begin
            vid_req = (c < 4);
            vid_addr = 10'(32 + c);
            if (c < 4) vq.push_back(init_val(32 + c));
            tick();
            if (c + 1 == 3) check("t3_vid_a2", 32'(o_RAM_ADDR), 34);
            if (c + 1 == 4) begin
                check("t3_cpu_gnt", 32'(o_RAM_ADDR), 32'h3A5);
                check("t3_cpu_rd", 32'(o_RAM_RD), 1);
            end
            if (c + 1 == 5) check("t3_vid_defer", 32'(o_RAM_ADDR), 35);
            if (o_CPU_ACK) begin
                check("t3_ack_cyc", 32'(c + 1), 6);
                got = 1'b1;
                cpu_req = 1'b0;
            end
        end
        vid_req = 1'b0;
        check("t3_ack_seen", 32'(got), 1);
        check("t3_ovf", 32'(o_VID_OVF), 0);
        tick();

        // T4: strobe arriving while the deferral slot is full is dropped
        got = 1'b0;
        cpu_req = 1'b1;
        cpu_addr = 10'h3A5;
        cq.push_back({1'b0, exp_mem[10'h3A5]});
        for (int c = 0; c < 10; c++) begin
            vid_req = (c < 5);
            vid_addr = 10'(64 + c);
            if (c < 4) vq.push_back(init_val(64 + c));
            tick();
            if (c + 1 == 5) check("t4_pend_first", 32'(o_RAM_ADDR), 67);
            if (c + 1 == 6) check("t4_ovf_set", 32'(o_VID_OVF), 1);
            if (o_CPU_ACK) begin
                got = 1'b1;
                cpu_req = 1'b0;
            end
        end
        vid_req = 1'b0;
        check("t4_ack_seen", 32'(got), 1);
        check("t4_ovf_sticky", 32'(o_VID_OVF), 1);
        tick();

        // T5: REQ held through ACK
        am = '0;
        rm = '0;
        cpu_req = 1'b1;
        cpu_addr = 10'h123;
        cq.push_back({1'b0, exp_mem[10'h123]});
        cq.push_back({1'b0, exp_mem[10'h123]});
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (o_CPU_ACK) am[n] = 1'b1;
            if (o_RAM_RD && o_RAM_ADDR == 10'h123) rm[n] = 1'b1;
            if (n == 7) cpu_req = 1'b0;
        end
        check("t5_ack_cycles", 32'(am), 32'h088);
        check("t5_rd_cycles", 32'(rm), 32'h022);
        check("t5_ovf_sticky", 32'(o_VID_OVF), 1);
        tick();

        // T6: reset during a CPU write RAM cycle
        cpu_req = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = 10'h200;
        cpu_din = 8'h99;
        tick();
        check("t6_wr_on", 32'(o_RAM_WR), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_wr_async", 32'(o_RAM_WR), 0);
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        last_rd = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk_idle("t6_post");
        cpu_op(1'b0, 10'h200, 8'h00);

        repeat (4) tick();
        check("cpu_sb_drain", 32'(cq.size()), 0);
        check("vid_sb_drain", 32'(vq.size()), 0);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
